// File: rtl/types_pkg.sv
// Shared types and constants for the register-rename stage of the RV32I
// out-of-order core.
//   decode_data : packet arriving from decode
//   rename_data : decode packet plus physical source/destination tags
//   is_alloc()  : whether an op claims a new physical destination register
package types_pkg;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 128;
  localparam int PREG_W   = $clog2(NUM_PHYS);
  localparam int AREG_W   = $clog2(NUM_ARCH);
  localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    areg_t       rs1;
    areg_t       rs2;
    areg_t       rd;
    logic [31:0] imm;
    logic [2:0]  alu_op;
    logic [1:0]  fu;
  } decode_data;

  typedef struct packed {
    decode_data dec;
    preg_t      ps1;
    preg_t      ps2;
    preg_t      pd_new;
    preg_t      pd_old;
  } rename_data;

  // STORE and BRANCH reuse the rd field for immediate bits; x0 is never renamed.
  function automatic logic is_alloc(input decode_data d);
    return (d.rd != '0) && (d.opcode != STORE) && (d.opcode != BRANCH);
  endfunction

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical registers, preloaded at reset with
// p32..p127 in ascending order (head = p32).
//   push / push_preg : ROB returns a register (p0 and pushes while full are dropped)
//   pop  / pop_preg  : rename claims the head entry (pop_preg is valid when !empty)
//   empty / full     : occupancy flags
// With RENAME_CHECKPOINT_EN defined, extra ports expose head/count for a
// snapshot and accept a restore of head (count is re-derived from the tail).
module free_list
  import types_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  preg_t push_preg,
  input  logic  pop,
  output preg_t pop_preg,
  output logic  empty,
  output logic  full
`ifdef RENAME_CHECKPOINT_EN
  ,
  input  logic                         restore,
  input  logic [$clog2(FL_DEPTH)-1:0]  restore_head,
  input  logic [$clog2(FL_DEPTH+1)-1:0] restore_count,
  output logic [$clog2(FL_DEPTH)-1:0]  head_idx,
  output logic [$clog2(FL_DEPTH+1)-1:0] count_out
`endif
);

  localparam int IDX_W = $clog2(FL_DEPTH);
  localparam int CNT_W = $clog2(FL_DEPTH + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  preg_t mem [FL_DEPTH];
  idx_t  head;
  idx_t  tail;
  cnt_t  count;

  logic push_ok;
  logic pop_ok;
  idx_t tail_nxt;

  function automatic idx_t wrap_inc(input idx_t i);
    return (i == idx_t'(FL_DEPTH - 1)) ? '0 : i + idx_t'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == cnt_t'(FL_DEPTH));
  assign pop_preg = mem[head];
  assign push_ok  = push && (push_preg != '0) && !full;
  assign pop_ok   = pop && !empty;
  assign tail_nxt = push_ok ? wrap_inc(tail) : tail;

`ifdef RENAME_CHECKPOINT_EN
  // Entries between the restored head and the (post-push) tail are free.
  // head == tail is ambiguous; the snapshot count is nonzero whenever the
  // list was not empty at the branch, and only pushes happen afterwards.
  logic [IDX_W:0] diff;
  cnt_t           restored_count;

  always_comb begin
    diff = {1'b0, tail_nxt} + (IDX_W+1)'(FL_DEPTH) - {1'b0, restore_head};
    if (diff >= (IDX_W+1)'(FL_DEPTH)) diff = diff - (IDX_W+1)'(FL_DEPTH);
    if (diff == '0 && restore_count != '0) restored_count = cnt_t'(FL_DEPTH);
    else                                   restored_count = cnt_t'(diff);
  end

  assign head_idx  = head;
  assign count_out = count;
`endif

  // NOTE: the storage is reset on purpose -- the preload is the initial free
  // set, not a don't-care. Sequential state uses <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_DEPTH; i++) mem[i] <= preg_t'(NUM_ARCH + i);
      head  <= '0;
      tail  <= '0;
      count <= cnt_t'(FL_DEPTH);
    end else begin
      if (push_ok) mem[tail] <= push_preg;
      tail <= tail_nxt;
`ifdef RENAME_CHECKPOINT_EN
      if (restore) begin
        head  <= restore_head;
        count <= restored_count;
      end else
`endif
      begin
        if (pop_ok) head <= wrap_inc(head);
        count <= count + cnt_t'(push_ok) - cnt_t'(pop_ok);
      end
    end
  end

endmodule

// File: rtl/rename.sv
// Register-rename stage between decode and dispatch/ROB.
//   valid_in/data_in/ready_in      : decode handshake (rename accepts on valid_in && ready_in)
//   data_out/valid_out/ready_out   : registered rename packet to dispatch, 1-cycle latency
//   write_en/rob_data_in           : ROB returns a retired physical register to the free list
//   mispredict                     : flush; clears the output register, blocks acceptance
// Optional RENAME_CHECKPOINT_EN: single map/free-list checkpoint taken on each
// accepted BRANCH and restored on mispredict. Without it, mispredict only
// flushes the output register.
module rename
  import types_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  decode_data data_in,
  output logic       ready_in,
  input  logic       write_en,
  input  preg_t      rob_data_in,
  input  logic       mispredict,
  output rename_data data_out,
  output logic       valid_out,
  input  logic       ready_out
);

  preg_t      map_q [NUM_ARCH];
  rename_data pkt;
  logic       alloc;
  logic       fire;
  logic       fl_empty;
  logic       fl_full;
  preg_t      fl_head;

`ifdef RENAME_CHECKPOINT_EN
  preg_t                         snap_map [NUM_ARCH];
  logic [$clog2(FL_DEPTH)-1:0]   snap_head;
  logic [$clog2(FL_DEPTH+1)-1:0] snap_count;
  logic [$clog2(FL_DEPTH)-1:0]   fl_head_idx;
  logic [$clog2(FL_DEPTH+1)-1:0] fl_count;
`endif

  assign alloc    = is_alloc(data_in);
  assign ready_in = (!valid_out || ready_out) && !(alloc && fl_empty) && !mispredict;
  assign fire     = valid_in && ready_in;

  free_list u_free_list (
    .clk       (clk),
    .reset     (reset),
    .push      (write_en),
    .push_preg (rob_data_in),
    .pop       (fire && alloc),
    .pop_preg  (fl_head),
    .empty     (fl_empty),
    .full      (fl_full)
`ifdef RENAME_CHECKPOINT_EN
    ,
    .restore       (mispredict),
    .restore_head  (snap_head),
    .restore_count (snap_count),
    .head_idx      (fl_head_idx),
    .count_out     (fl_count)
`endif
  );

  // Sources read the map before this op's own rd update lands, so
  // "add x5,x5,.." sees the previous x5 mapping.
  // NOTE: every field gets a value before any branch so no latch is inferred.
  always_comb begin
    pkt        = '0;
    pkt.dec    = data_in;
    pkt.ps1    = map_q[data_in.rs1];
    pkt.ps2    = map_q[data_in.rs2];
    if (alloc) begin
      pkt.pd_new = fl_head;
      pkt.pd_old = map_q[data_in.rd];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ARCH; i++) map_q[i] <= preg_t'(i);
    end else begin
`ifdef RENAME_CHECKPOINT_EN
      if (mispredict) begin
        for (int i = 0; i < NUM_ARCH; i++) map_q[i] <= snap_map[i];
      end else
`endif
      if (fire && alloc) map_q[data_in.rd] <= fl_head;
    end
  end

`ifdef RENAME_CHECKPOINT_EN
  // A branch never allocates, so the current map is exactly the state to
  // resume from after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ARCH; i++) snap_map[i] <= preg_t'(i);
      snap_head  <= '0;
      snap_count <= ($clog2(FL_DEPTH+1))'(FL_DEPTH);
    end else if (fire && data_in.opcode == BRANCH) begin
      for (int i = 0; i < NUM_ARCH; i++) snap_map[i] <= map_q[i];
      snap_head  <= fl_head_idx;
      snap_count <= fl_count;
    end
  end
`endif

  // Output register: load on fire, hold while stalled, release after a
  // consumed beat with no replacement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (mispredict) begin
      valid_out <= 1'b0;
    end else if (fire) begin
      valid_out <= 1'b1;
      data_out  <= pkt;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rename.sv
module tb_rename;
  import types_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  decode_data data_in;
  logic       ready_in;
  logic       write_en;
  preg_t      rob_data_in;
  logic       mispredict;
  rename_data data_out;
  logic       valid_out;
  logic       ready_out;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] pc_cnt      = 32'h0000_1000;
  decode_data  last_op;

  always #5 clk = ~clk;

  rename dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .ready_in    (ready_in),
    .write_en    (write_en),
    .rob_data_in (rob_data_in),
    .mispredict  (mispredict),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .ready_out   (ready_out)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present an op at the falling edge; valid_in stays up until tick().
  task automatic drive(input logic [6:0] opc, input int rd, input int rs1,
                       input int rs2, input logic [31:0] imm);
    @(negedge clk);
    data_in.pc     = pc_cnt;
    data_in.opcode = opc;
    data_in.rd     = areg_t'(rd);
    data_in.rs1    = areg_t'(rs1);
    data_in.rs2    = areg_t'(rs2);
    data_in.imm    = imm;
    data_in.alu_op = pc_cnt[4:2];
    data_in.fu     = pc_cnt[3:2];
    pc_cnt         = pc_cnt + 32'd4;
    valid_in       = 1'b1;
    last_op        = data_in;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic expect_pkt(input string tag, input int ps1, input int ps2,
                            input int pd_new, input int pd_old);
    check({tag, ".valid"},  valid_out,       1);
    check({tag, ".dec"},    data_out.dec,    last_op);
    check({tag, ".ps1"},    data_out.ps1,    ps1);
    check({tag, ".ps2"},    data_out.ps2,    ps2);
    check({tag, ".pd_new"}, data_out.pd_new, pd_new);
    check({tag, ".pd_old"}, data_out.pd_old, pd_old);
  endtask

  initial begin
    reset       = 1'b0;
    valid_in    = 1'b0;
    data_in     = '0;
    write_en    = 1'b0;
    rob_data_in = '0;
    mispredict  = 1'b0;
    ready_out   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid_out", valid_out, 0);
    check("rst.data_out",  data_out,  0);
    check("rst.ready_in",  ready_in,  1);
    @(negedge clk);
    reset = 1'b1;

    // Free list is full out of reset: this push must be dropped.
    @(negedge clk);
    write_en = 1'b1; rob_data_in = 7'd9;
    @(posedge clk); #1;
    write_en = 1'b0;

    drive(OP_IMM, 5, 1, 2, 32'h0000_07ff);
    check("addi.ready_in", ready_in, 1);
    tick();
    expect_pkt("addi", 1, 2, 32, 5);

    drive(LOAD, 6, 5, 0, 32'h0);
    tick();
    expect_pkt("load", 32, 0, 33, 6);

    @(posedge clk); #1;
    check("release1.valid_out", valid_out, 0);

    drive(OP, 7, 6, 0, 32'h0);
    ready_out = 1'b0;
    #1;
    check("op.ready_in", ready_in, 1);
    tick();
    expect_pkt("op", 33, 0, 34, 7);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("hold.ready_in", ready_in, 0);
      @(posedge clk); #1;
      check("hold.valid_out", valid_out, 1);
      check("hold.pd_new", data_out.pd_new, 34);
    end
    @(negedge clk);
    ready_out = 1'b1;
    @(posedge clk); #1;
    check("release2.valid_out", valid_out, 0);

    drive(STORE, 3, 1, 2, 32'h0000_0003);
    tick();
    expect_pkt("store", 1, 2, 0, 0);

    drive(OP_IMM, 0, 1, 20, 32'h0000_1234);
    tick();
    expect_pkt("addi_x0", 1, 20, 0, 0);

    // Next alloc proves STORE/x0 did not pop and the full-push was dropped.
    drive(OP_IMM, 8, 8, 1, 32'h0000_0001);
    tick();
    expect_pkt("addi_x8", 8, 1, 35, 8);

    drive(OP, 9, 8, 5, 32'h0);
    check("b2b.ready_in", ready_in, 1);
    tick();
    expect_pkt("b2b", 35, 32, 36, 9);

    for (int i = 0; i < 91; i++) begin
      drive(OP, 10 + (i % 22), 0, 0, 32'h0);
      tick();
      check("drain.pd_new", data_out.pd_new, 37 + i);
    end

    // Free list empty: an alloc stalls, a non-alloc would still go through.
    drive(STORE, 4, 1, 2, 32'h0);
    valid_in = 1'b0;
    check("empty.store_ready", ready_in, 1);
    drive(OP_IMM, 1, 1, 0, 32'h0000_0010);
    check("empty.ready_in", ready_in, 0);
    write_en = 1'b1; rob_data_in = 7'd0;
    @(posedge clk); #1;
    write_en = 1'b0;
    check("push_p0.ready_in", ready_in, 0);
    @(negedge clk);
    write_en = 1'b1; rob_data_in = 7'd5;
    #1;
    check("no_bypass.ready_in", ready_in, 0);
    @(posedge clk); #1;
    write_en = 1'b0;
    check("refill.ready_in", ready_in, 1);
    tick();
    expect_pkt("realloc", 1, 0, 5, 1);

    // Mispredict: flush output, refuse the op, still accept the ROB free.
    @(negedge clk);
    ready_out   = 1'b0;
    mispredict  = 1'b1;
    write_en    = 1'b1;
    rob_data_in = 7'd7;
    data_in.opcode = STORE;
    valid_in    = 1'b1;
    #1;
    check("mispredict.ready_in", ready_in, 0);
    @(posedge clk); #1;
    mispredict = 1'b0;
    write_en   = 1'b0;
    valid_in   = 1'b0;
    ready_out  = 1'b1;
    check("mispredict.valid_out", valid_out, 0);

    drive(OP_IMM, 1, 1, 0, 32'h0000_0020);
    tick();
    expect_pkt("post_flush", 5, 0, 7, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
